lea_block_loader: RTL



---
 rtl/lea_block_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lea_block_loader.sv
// -----------------------------------------------------------------------------
// lea_block_loader
//
// Purpose:
//   Byte-serial input sequencer for the LEA core. Bytes from the host/UART
//   side are accepted one per valid/ready handshake. NBYTES of them are packed
//   into one block register, with the first byte in lane 0 (the LSBs). The
//   block is then presented to the core with a valid/ready handshake. A flush
//   pulse ends a partial block. A 16-bit counter tracks accepted blocks.
//
// Configuration macro:
//   LEA_LOADER_PAD_EN - when defined, a flush of a non-empty partial block
//                       issues that block zero-padded, with blk_nbytes set to
//                       the number of bytes collected. When undefined, the
//                       partial block is discarded.
//
// Parameters:
//   NBYTES  bytes per block (2..16); BW = 8*NBYTES, CW = $clog2(NBYTES)+1
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   din[7:0]       in   input byte
//   din_valid      in   din holds a byte
//   din_ready      out  loader accepts din this cycle
//   flush          in   one-cycle pulse: terminate the current partial block
//   blk_out[BW-1:0] out packed block to the LEA core
//   blk_valid      out  blk_out holds a complete block
//   blk_ready      in   core accepts blk_out
//   blk_nbytes[CW-1:0] out valid byte count in blk_out
//   blocks_issued[15:0] out count of accepted blocks (wraps)
// -----------------------------------------------------------------------------
module lea_block_loader #(
    parameter  int NBYTES = 16,
    localparam int BW     = 8 * NBYTES,
    localparam int CW     = $clog2(NBYTES) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    din,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic          flush,
    output logic [BW-1:0] blk_out,
    output logic          blk_valid,
    input  logic          blk_ready,
    output logic [CW-1:0] blk_nbytes,
    output logic [15:0]   blocks_issued
);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [BW-1:0] r_blk;
    logic [BW-1:0] w_blk_next;
    logic [CW-1:0] r_nbytes;
    logic [CW-1:0] w_nbytes_next;
    logic [15:0]   r_issued;
    logic [15:0]   w_issued_next;

    logic          w_din_ready;
    logic          w_accept;
    logic          w_last_byte;
    logic          w_flush_partial;
    logic [NBYTES-1:0] w_lane_wr;
    logic [BW-1:0] w_blk_written;

    // flush is the only combinational input into din_ready; it blocks the
    // handshake so a byte presented alongside flush is not consumed.
    assign w_din_ready     = (r_state == S_COLLECT) && !flush;
    assign w_accept        = din_valid && w_din_ready;
    assign w_last_byte     = (r_cnt == CW'(NBYTES - 1));
    assign w_flush_partial = (r_state == S_COLLECT) && flush && (r_cnt != '0);

    // One write-enable per byte lane; the lane addressed by the byte counter
    // takes din on an accept, every other lane keeps its contents.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign w_lane_wr[gi] = w_accept && (r_cnt == CW'(gi));
            assign w_blk_written[8*gi +: 8] = w_lane_wr[gi] ? din : r_blk[8*gi +: 8];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_blk    <= '0;
            r_nbytes <= '0;
            r_issued <= '0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_blk    <= w_blk_next;
            r_nbytes <= w_nbytes_next;
            r_issued <= w_issued_next;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_blk_next    = r_blk;
        w_nbytes_next = r_nbytes;
        w_issued_next = r_issued;

        case (r_state)
            S_INIT: begin
                w_state_next = S_COLLECT;
            end

            S_COLLECT: begin
                if (w_flush_partial) begin
                    w_cnt_next = '0;
`ifdef LEA_LOADER_PAD_EN
                    // Issue what was collected; lanes never written are
                    // still zero from the last clear.
                    w_nbytes_next = r_cnt;
                    w_state_next  = S_HOLD;
`else
                    w_blk_next    = '0;
`endif
                end else if (w_accept) begin
                    w_blk_next = w_blk_written;
                    if (w_last_byte) begin
                        w_cnt_next    = '0;
                        w_nbytes_next = CW'(NBYTES);
                        w_state_next  = S_HOLD;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end

            S_HOLD: begin
                // Block and count stay frozen until the core takes them.
                if (blk_ready) begin
                    w_issued_next = r_issued + 16'd1;
                    w_blk_next    = '0;
                    w_nbytes_next = '0;
                    w_state_next  = S_COLLECT;
                end
            end

            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    assign din_ready     = w_din_ready;
    assign blk_valid     = (r_state == S_HOLD);
    assign blk_out       = r_blk;
    assign blk_nbytes    = r_nbytes;
    assign blocks_issued = r_issued;

endmodule
